// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for one shared valid/ready destination bus.
// A grant is held for a whole packet, or until MAX_BURST beats have been
// accepted. When a grant is released, the round-robin pointer moves just past
// the master that was granted, and there is one idle cycle before the next grant.
// The FSM state is visible on busy_o (1 = BUSY, 0 = IDLE).
//
// Handshake: a beat is transferred on a posedge where s_valid_o && s_ready_i.
// Only the granted master can see ready. Masters hold valid/data/last stable
// until their beat is accepted.
module bus_rr_arbiter #(
    parameter int N_MST     = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_MST-1:0]    m_valid_i,
    input  logic [N_MST*DW-1:0] m_data_i,
    input  logic [N_MST-1:0]    m_last_i,
    output logic [N_MST-1:0]    m_ready_o,
    output logic                s_valid_o,
    output logic [DW-1:0]       s_data_o,
    output logic                s_last_o,
    input  logic                s_ready_i,
    output logic [N_MST-1:0]    grant_o,
    output logic                busy_o
);

    localparam int IW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CW-1:0] BURST_LAST = (MAX_BURST > 0) ? CW'(MAX_BURST - 1) : '0;
    localparam logic [IW-1:0] LAST_IDX   = IW'(N_MST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N_MST-1:0] grant_q, grant_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;

    logic             req_found;
    logic [IW-1:0]    req_idx;
    logic             sel_valid;
    logic             sel_last;
    logic             beat_acc;
    logic             release_now;

    // Find the first requester, searching upward from rr_ptr and wrapping to 0.
    always_comb begin
        int cand;
        cand      = 0;
        req_found = 1'b0;
        req_idx   = '0;
        for (int i = 0; i < N_MST; i++) begin
            cand = (int'(rr_ptr_q) + i) % N_MST;
            if (!req_found && m_valid_i[cand]) begin
                req_found = 1'b1;
                req_idx   = IW'(cand);
            end
        end
    end

    assign sel_valid   = (state_q == BUSY) && m_valid_i[gidx_q];
    assign sel_last    = m_last_i[gidx_q];
    assign beat_acc    = sel_valid && s_ready_i;
    assign release_now = beat_acc &&
                         (sel_last || ((MAX_BURST != 0) && (beat_cnt_q == BURST_LAST)));

    // Combinational bus mux. Data and last are forced to 0 while the bus is not valid.
    always_comb begin
        s_valid_o = 1'b0;
        s_data_o  = '0;
        s_last_o  = 1'b0;
        m_ready_o = '0;
        busy_o    = (state_q == BUSY);
        grant_o   = grant_q;
        if (state_q == BUSY) begin
            s_valid_o         = sel_valid;
            m_ready_o[gidx_q] = s_ready_i;
            if (sel_valid) begin
                s_data_o = m_data_i[gidx_q*DW +: DW];
                s_last_o = sel_last;
            end
        end
    end

    // Next-state logic: grant from IDLE, count beats and release in BUSY.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    state_d    = BUSY;
                    gidx_d     = req_idx;
                    grant_d    = {{(N_MST-1){1'b0}}, 1'b1} << req_idx;
                    beat_cnt_d = '0;
                end
            end
            BUSY: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if (release_now) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
